// File: rtl/polyplay_pkg.sv
// Shared types and constants for the Poly-Play NVRAM upload path.
// Holds the request FSM encoding and the default NVRAM geometry.
package polyplay_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } fsm_e;

  localparam logic [7:0] NVRAM_INDEX  = 8'd4;
  localparam int         NVRAM_ADDR_W = 10;

  typedef logic [23:0] tick_t;

endpackage

// File: rtl/nvram_upload_server_if.sv
// ioctl upload channel between hps_io (master) and the core (slave).
// Carries the byte read request and the returned data/stall.
interface nvram_upload_server_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload,
    output ioctl_index,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_index,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait
  );
endinterface

// File: rtl/nvram_dirty_timer.sv
// Tracks core writes to NVRAM and requests an autosave after a
// quiet period; an upload that saw no writes clears the dirty flag.
module nvram_dirty_timer
  import polyplay_pkg::*;
#(
  parameter tick_t IDLE_TICKS = 24'd5_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic core_we,
  input  logic ioctl_upload,
  input  logic upload_end,
  output logic dirty,
  output logic save_req
);

  tick_t cnt_q, cnt_d;
  logic  dirty_q, dirty_d;
  logic  sess_we_q, sess_we_d;

  always_comb begin
    cnt_d     = cnt_q;
    dirty_d   = dirty_q;
    sess_we_d = ioctl_upload & (sess_we_q | core_we);
    if (core_we) begin
      cnt_d = IDLE_TICKS;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - tick_t'(1);
    end
    // A write anywhere in the session keeps the data dirty
    if (upload_end) begin
      dirty_d = sess_we_q | core_we;
    end else if (core_we) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      dirty_q   <= 1'b0;
      sess_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dirty_q   <= dirty_d;
      sess_we_q <= sess_we_d;
    end
  end

  assign dirty    = dirty_q;
  assign save_req = dirty_q & ~ioctl_upload & ~core_we
                  & (cnt_q == tick_t'(1));

endmodule

// File: rtl/nvram_upload_server.sv
// Serves HPS byte upload requests from the NVRAM read port and
// raises autosave requests after core-side writes go quiet.
module nvram_upload_server
  import polyplay_pkg::*;
#(
  parameter int         ADDR_W       = NVRAM_ADDR_W,
  parameter int         RAM_LAT      = 1,
  parameter logic [7:0] UPLOAD_INDEX = NVRAM_INDEX,
  parameter tick_t      IDLE_TICKS   = 24'd5_000_000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  nvram_upload_server_if.slave  ioctl,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_rd,
  input  logic [7:0]            ram_q,
  input  logic                  core_we,
  output logic                  save_req,
  output logic                  dirty
);

  localparam logic [2:0] LAT_N = 3'(RAM_LAT);

  fsm_e              state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              upload_q;
  logic              idx_hit, sel, in_range, upload_end;

  assign idx_hit    = ioctl.ioctl_index == UPLOAD_INDEX;
  assign sel        = ioctl.ioctl_upload & idx_hit & ioctl.ioctl_rd;
  assign in_range   = ~|ioctl.ioctl_addr[24:ADDR_W];
  assign upload_end = upload_q & ~ioctl.ioctl_upload & idx_hit;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    din_d   = din_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel && in_range) begin
          addr_d  = ioctl.ioctl_addr[ADDR_W-1:0];
          rd_d    = 1'b1;
          wait_d  = 1'b1;
          lat_d   = '0;
          state_d = S_FETCH;
        end else if (sel) begin
          din_d = 8'hFF;
        end
      end
      S_FETCH: begin
        // ram_q is valid RAM_LAT cycles after the strobe cycle
        if (lat_q == LAT_N) begin
          din_d   = ram_q;
          wait_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      upload_q <= ioctl.ioctl_upload;
    end
  end

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = wait_q;
  assign ram_addr         = addr_q;
  assign ram_rd           = rd_q;

  nvram_dirty_timer #(
    .IDLE_TICKS (IDLE_TICKS)
  ) u_timer (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .core_we      (core_we),
    .ioctl_upload (ioctl.ioctl_upload),
    .upload_end   (upload_end),
    .dirty        (dirty),
    .save_req     (save_req)
  );

endmodule

// File: tb/tb_nvram_upload_server.sv
// Directed bench: one instance with 1-cycle RAM, one with 3-cycle RAM,
// both driven from the same ioctl stimulus.
module tb_nvram_upload_server;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       core_we;
  logic [9:0] ram_addr1, ram_addr3;
  logic       ram_rd1, ram_rd3;
  logic [7:0] ram_q1, ram_q3, p0, p1;
  logic       save1, save3, dirty1, dirty3;
  logic [7:0] mem [1024];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_save;
  int         save_at;

  always #5 clk = ~clk;

  nvram_upload_server_if bus1();
  nvram_upload_server_if bus3();

  assign bus3.ioctl_upload = bus1.ioctl_upload;
  assign bus3.ioctl_index  = bus1.ioctl_index;
  assign bus3.ioctl_rd     = bus1.ioctl_rd;
  assign bus3.ioctl_addr   = bus1.ioctl_addr;

  nvram_upload_server #(
    .ADDR_W (10), .RAM_LAT (1),
    .UPLOAD_INDEX (8'd4), .IDLE_TICKS (24'd100)
  ) dut1 (
    .clk_sys (clk), .reset_n (reset_n), .ioctl (bus1),
    .ram_addr (ram_addr1), .ram_rd (ram_rd1), .ram_q (ram_q1),
    .core_we (core_we), .save_req (save1), .dirty (dirty1)
  );

  nvram_upload_server #(
    .ADDR_W (10), .RAM_LAT (3),
    .UPLOAD_INDEX (8'd4), .IDLE_TICKS (24'd100)
  ) dut3 (
    .clk_sys (clk), .reset_n (reset_n), .ioctl (bus3),
    .ram_addr (ram_addr3), .ram_rd (ram_rd3), .ram_q (ram_q3),
    .core_we (core_we), .save_req (save3), .dirty (dirty3)
  );

  always @(posedge clk) begin
    if (ram_rd1) ram_q1 <= mem[ram_addr1];
    p0     <= mem[ram_addr3];
    p1     <= p0;
    ram_q3 <= p1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h123] = 8'h5A;
    mem[10'h045] = 8'h3C;
    mem[10'h200] = 8'hA7;
    reset_n           = 1'b0;
    core_we           = 1'b0;
    bus1.ioctl_upload = 1'b0;
    bus1.ioctl_index  = 8'd0;
    bus1.ioctl_rd     = 1'b0;
    bus1.ioctl_addr   = '0;
    repeat (3) step();
    chk("rst_din", bus1.ioctl_din, 8'h00);
    chk("rst_wait", bus1.ioctl_wait, 0);
    chk("rst_addr", ram_addr1, 0);
    chk("rst_rd", ram_rd1, 0);
    chk("rst_save", save1, 0);
    chk("rst_dirty", dirty1, 0);
    reset_n = 1'b1;
    step();

    // in-range read, RAM_LAT=1
    bus1.ioctl_upload = 1'b1;
    bus1.ioctl_index  = 8'd4;
    bus1.ioctl_addr   = 25'h123;
    bus1.ioctl_rd     = 1'b1;
    step();
    bus1.ioctl_rd = 1'b0;
    chk("rd_c1_rd", ram_rd1, 1);
    chk("rd_c1_addr", ram_addr1, 10'h123);
    chk("rd_c1_wait", bus1.ioctl_wait, 1);
    step();
    chk("rd_c2_wait", bus1.ioctl_wait, 1);
    chk("rd_c2_rd", ram_rd1, 0);
    step();
    chk("rd_c3_wait", bus1.ioctl_wait, 0);
    chk("rd_c3_din", bus1.ioctl_din, 8'h5A);
    repeat (4) step();

    // out-of-range read
    bus1.ioctl_addr = 25'h400;
    bus1.ioctl_rd   = 1'b1;
    step();
    bus1.ioctl_rd = 1'b0;
    chk("oor_din", bus1.ioctl_din, 8'hFF);
    chk("oor_rd", ram_rd1, 0);
    chk("oor_wait", bus1.ioctl_wait, 0);
    step();
    chk("oor_wait2", bus1.ioctl_wait, 0);

    // wrong index
    bus1.ioctl_index = 8'd0;
    bus1.ioctl_addr  = 25'h123;
    bus1.ioctl_rd    = 1'b1;
    step();
    bus1.ioctl_rd    = 1'b0;
    bus1.ioctl_index = 8'd4;
    chk("idx_rd", ram_rd1, 0);
    chk("idx_din", bus1.ioctl_din, 8'hFF);
    step();

    // stray ioctl_rd during FETCH
    bus1.ioctl_addr = 25'h045;
    bus1.ioctl_rd   = 1'b1;
    step();
    bus1.ioctl_addr = 25'h200;
    step();
    bus1.ioctl_rd = 1'b0;
    chk("pv_addr", ram_addr1, 10'h045);
    chk("pv_rd", ram_rd1, 0);
    step();
    chk("pv_din", bus1.ioctl_din, 8'h3C);
    chk("pv_wait", bus1.ioctl_wait, 0);
    bus1.ioctl_upload = 1'b0;
    repeat (6) step();

    // autosave after quiet period
    n_save  = 0;
    save_at = -1;
    for (int c = 0; c <= 200; c++) begin
      core_we = (c == 0) || (c == 50);
      #1;
      if (save1) begin
        n_save++;
        save_at = c;
      end
      @(posedge clk);
      #1;
    end
    chk("as_count", n_save, 1);
    chk("as_cycle", save_at, 150);
    chk("as_dirty", dirty1, 1);
    bus1.ioctl_upload = 1'b1;
    step();
    bus1.ioctl_upload = 1'b0;
    chk("ue_dirty_pre", dirty1, 1);
    step();
    chk("ue_dirty_clr", dirty1, 0);
    step();

    // write during upload session
    n_save  = 0;
    save_at = -1;
    for (int c = 0; c <= 150; c++) begin
      core_we           = (c == 0);
      bus1.ioctl_upload = (c < 5);
      #1;
      if (c == 0) chk("wu_dirty0", dirty1, 0);
      if (c == 7) chk("wu_dirty_end", dirty1, 1);
      if (save1) begin
        n_save++;
        save_at = c;
      end
      @(posedge clk);
      #1;
    end
    chk("wu_count", n_save, 1);
    chk("wu_cycle", save_at, 100);

    // reset during FETCH, RAM_LAT=3
    bus1.ioctl_upload = 1'b1;
    bus1.ioctl_addr   = 25'h123;
    bus1.ioctl_rd     = 1'b1;
    step();
    bus1.ioctl_rd = 1'b0;
    chk("rm_rd", ram_rd3, 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rm_wait", bus3.ioctl_wait, 0);
    chk("rm_rd0", ram_rd3, 0);
    chk("rm_addr", ram_addr3, 0);
    chk("rm_din", bus3.ioctl_din, 8'h00);
    chk("rm_dirty", dirty3, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rm_hold_rd", ram_rd3, 0);
    end
    reset_n = 1'b1;
    step();
    step();
    chk("rm_late_din", bus3.ioctl_din, 8'h00);
    chk("rm_late_wait", bus3.ioctl_wait, 0);
    bus1.ioctl_addr = 25'h045;
    bus1.ioctl_rd   = 1'b1;
    step();
    bus1.ioctl_rd = 1'b0;
    chk("rn_rd", ram_rd3, 1);
    chk("rn_addr", ram_addr3, 10'h045);
    step();
    step();
    step();
    chk("rn_c4_wait", bus3.ioctl_wait, 1);
    step();
    chk("rn_c5_wait", bus3.ioctl_wait, 0);
    chk("rn_c5_din", bus3.ioctl_din, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
